// File: rtl/led_ws2812_tx.sv
// WS2812 one-wire transmitter: pops NUM_LEDS GRB words from the LED FIFO,
// serialises them MSB-first, then holds the line low for the frame latch.
module led_ws2812_tx #(
  parameter int DATA_W       = 24,
  parameter int NUM_LEDS     = 8,
  parameter int TBIT         = 62,
  parameter int T0H          = 20,
  parameter int T1H          = 40,
  parameter int RESET_CYCLES = 3000
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              send_start,
  input  logic              fifo_empty,
  input  logic [DATA_W-1:0] fifo_rd_data,
  output logic              fifo_rd_en,
  output logic              dout,
  output logic              busy,
  output logic              done,
  output logic              err_underrun
);

  localparam int CYC_W  = $clog2(TBIT);
  localparam int BIT_W  = $clog2(DATA_W);
  localparam int WORD_W = $clog2(NUM_LEDS + 1);
  localparam int LAT_W  = $clog2(RESET_CYCLES + 1);

  localparam logic [CYC_W-1:0]  CYC_LAST  = CYC_W'(TBIT - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_W - 1);
  localparam logic [WORD_W-1:0] WORD_LAST = WORD_W'(NUM_LEDS - 1);
  localparam logic [LAT_W-1:0]  LAT_LAST  = LAT_W'(RESET_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LOAD,
    S_BIT,
    S_LATCH,
    S_DONE
  } state_t;

  state_t              state;
  logic [DATA_W-1:0]   shift_reg;
  logic [CYC_W-1:0]    cyc_cnt;
  logic [BIT_W-1:0]    bit_cnt;
  logic [WORD_W-1:0]   word_cnt;
  logic [LAT_W-1:0]    latch_cnt;

  function automatic logic [CYC_W-1:0] hi_len(input logic b);
    return b ? CYC_W'(T1H) : CYC_W'(T0H);
  endfunction

  // dout is registered, so every branch computes the level for the next cycle.
  // The pop decision is taken on the edge that enters FETCH; only this block
  // pops the FIFO, so it cannot drain between that edge and the pop.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state        <= S_IDLE;
      dout         <= 1'b0;
      fifo_rd_en   <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      err_underrun <= 1'b0;
      cyc_cnt      <= '0;
      bit_cnt      <= '0;
      word_cnt     <= '0;
      latch_cnt    <= '0;
    end else begin
      done       <= 1'b0;
      fifo_rd_en <= 1'b0;
      case (state)
        S_IDLE: begin
          dout <= 1'b0;
          if (send_start) begin
            state        <= S_FETCH;
            busy         <= 1'b1;
            err_underrun <= 1'b0;
            word_cnt     <= '0;
            fifo_rd_en   <= !fifo_empty;
          end
        end
        S_FETCH: begin
          if (fifo_rd_en) begin
            state <= S_LOAD;
          end else begin
            err_underrun <= 1'b1;
            latch_cnt    <= '0;
            state        <= S_LATCH;
          end
        end
        S_LOAD: begin
          shift_reg <= fifo_rd_data;
          bit_cnt   <= BIT_LAST;
          cyc_cnt   <= '0;
          dout      <= (hi_len(fifo_rd_data[DATA_W-1]) != '0);
          state     <= S_BIT;
        end
        S_BIT: begin
          if (cyc_cnt == CYC_LAST) begin
            cyc_cnt   <= '0;
            shift_reg <= {shift_reg[DATA_W-2:0], 1'b0};
            if (bit_cnt == '0) begin
              dout     <= 1'b0;
              word_cnt <= word_cnt + 1'b1;
              if (word_cnt == WORD_LAST) begin
                latch_cnt <= '0;
                state     <= S_LATCH;
              end else begin
                fifo_rd_en <= !fifo_empty;
                state      <= S_FETCH;
              end
            end else begin
              bit_cnt <= bit_cnt - 1'b1;
              dout    <= (hi_len(shift_reg[DATA_W-2]) != '0);
            end
          end else begin
            cyc_cnt <= cyc_cnt + 1'b1;
            dout    <= ((cyc_cnt + 1'b1) < hi_len(shift_reg[DATA_W-1]));
          end
        end
        S_LATCH: begin
          dout <= 1'b0;
          if (latch_cnt == LAT_LAST) begin
            done  <= 1'b1;
            state <= S_DONE;
          end else begin
            latch_cnt <= latch_cnt + 1'b1;
          end
        end
        S_DONE: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_led_ws2812_tx.sv
// Bench for led_ws2812_tx: FIFO models, a dout decoder feeding a word
// scoreboard, and directed frame scenarios on an 8-LED and a 1-LED instance.
module tb_led_ws2812_tx;

  localparam int DW = 24, TB = 62, T0 = 20, T1 = 40, RC = 3000, NL = 8;
  localparam int WORD_CYC = 2 + DW * TB;

  logic clk = 1'b0;
  logic rstn = 1'b0;

  logic          start, empty = 1'b1, rd_en, dout, busy, done, err;
  logic [DW-1:0] rd_data;
  logic          start1, empty1 = 1'b1, rd_en1, dout1, busy1, done1, err1;
  logic [DW-1:0] rd_data1;

  logic [DW-1:0] fq[$];
  logic [DW-1:0] fq1[$];
  logic [DW-1:0] expq[$];

  int passed = 0, total = 0;
  int rd_cnt = 0, done_cnt = 0, rd_cnt1 = 0, done_cnt1 = 0;

  always #10 clk = ~clk;

  led_ws2812_tx #(.DATA_W(DW), .NUM_LEDS(NL), .TBIT(TB), .T0H(T0), .T1H(T1),
                  .RESET_CYCLES(RC)) dut (
    .clk(clk), .rstn(rstn), .send_start(start), .fifo_empty(empty),
    .fifo_rd_data(rd_data), .fifo_rd_en(rd_en), .dout(dout), .busy(busy),
    .done(done), .err_underrun(err));

  led_ws2812_tx #(.DATA_W(DW), .NUM_LEDS(1), .TBIT(TB), .T0H(T0), .T1H(T1),
                  .RESET_CYCLES(RC)) dut1 (
    .clk(clk), .rstn(rstn), .send_start(start1), .fifo_empty(empty1),
    .fifo_rd_data(rd_data1), .fifo_rd_en(rd_en1), .dout(dout1), .busy(busy1),
    .done(done1), .err_underrun(err1));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
  endtask

  // FIFO read ports: data appears the cycle after the pop strobe
  always @(posedge clk) begin
    if (rd_en && fq.size() > 0) rd_data <= fq.pop_front();
    if (rd_en1 && fq1.size() > 0) rd_data1 <= fq1.pop_front();
  end

  always @(negedge clk) begin
    if (rd_en) begin
      rd_cnt++;
      chk("rd_en_while_empty", empty, 1'b0);
    end
    if (done) done_cnt++;
    if (rd_en1) rd_cnt1++;
    if (done1) done_cnt1++;
    empty  = (fq.size() == 0);
    empty1 = (fq1.size() == 0);
  end

  // dout decoder for the 8-LED instance
  int h = 0, l = 1000, nb = 0;
  logic pd = 1'b0;
  logic [DW-1:0] w = '0, nw, ew;
  always @(negedge clk) begin
    if (!rstn) begin
      nb = 0; l = 1000; h = 0; pd = 1'b0;
    end else begin
      if (dout) begin
        if (!pd) begin
          if (l < 100) chk("bit_period", h + l, (nb == 0) ? TB + 2 : TB);
          h = 1;
        end else h++;
      end else if (pd) begin
        chk("bit_high_len", (h == T0 || h == T1), 1'b1);
        nw = {w[DW-2:0], (h == T1)};
        w  = nw;
        nb++;
        if (nb == DW) begin
          nb = 0;
          if (expq.size() == 0) chk("word_unexpected", 1'b1, 1'b0);
          else begin
            ew = expq.pop_front();
            chk("word", nw, ew);
          end
        end
        l = 1;
      end else if (l < 100000) l++;
      pd = dout;
    end
  end

  task automatic frame8(input int poke_a, input int poke_b, input int hold_at,
                        output int span, output int busy_bad);
    start = 1'b1;
    span = 1;
    busy_bad = 0;
    while (span < 20000) begin
      @(negedge clk);
      span++;
      start = (span == poke_a) || (span == poke_b) || (hold_at != 0 && span >= hold_at);
      if (span == 2) begin
        chk("lat_rd_en", rd_en, 1'b1);
        chk("err_cleared_on_accept", err, 1'b0);
      end
      if (span == 3) begin
        chk("lat_rd_en_pulse", rd_en, 1'b0);
        chk("lat_dout_low", dout, 1'b0);
      end
      if (span == 4) chk("lat_dout_rise", dout, 1'b1);
      if (!busy) busy_bad++;
      if (done) break;
    end
  endtask

  initial begin
    int span, bb, bad, lat, r0, d0;
    logic [DW-1:0] word1;
    logic expd;
    start = 1'b0;
    start1 = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_dout", dout, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_rd_en", rd_en, 1'b0);
    chk("rst_err", err, 1'b0);
    chk("rst_dout1", dout1, 1'b0);
    rstn = 1'b1;
    @(negedge clk);

    // Single word on the 1-LED instance, waveform compared cycle by cycle
    word1 = 24'hFF00A5;
    fq1.push_back(word1);
    repeat (2) @(negedge clk);
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    chk("t1_rd_en_lat", rd_en1, 1'b1);
    chk("t1_busy", busy1, 1'b1);
    @(negedge clk);
    chk("t1_rd_en_pulse", rd_en1, 1'b0);
    chk("t1_dout_pre", dout1, 1'b0);
    @(negedge clk);
    chk("t1_dout_rise", dout1, 1'b1);
    bad = 0;
    for (int b = DW - 1; b >= 0; b--) begin
      for (int c = 0; c < TB; c++) begin
        expd = (c < (word1[b] ? T1 : T0));
        if (dout1 !== expd) bad++;
        @(negedge clk);
      end
    end
    chk("t1_waveform_bad_cycles", bad, 0);
    lat = 0;
    bad = 0;
    while (!done1 && lat < 4000) begin
      if (dout1) bad++;
      lat++;
      @(negedge clk);
    end
    chk("t1_latch_len", lat, RC);
    chk("t1_latch_low", bad, 0);
    chk("t1_done", done1, 1'b1);
    @(negedge clk);
    chk("t1_done_pulse", done1, 1'b0);
    chk("t1_busy_drop", busy1, 1'b0);
    chk("t1_rd_count", rd_cnt1, 1);
    chk("t1_done_count", done_cnt1, 1);
    chk("t1_err", err1, 1'b0);

    // Full 8-word frame, with start-to-rd_en/dout latency
    for (int i = 1; i <= NL; i++) begin
      fq.push_back(DW'(i));
      expq.push_back(DW'(i));
    end
    repeat (2) @(negedge clk);
    r0 = rd_cnt; d0 = done_cnt;
    frame8(0, 0, 0, span, bb);
    start = 1'b0;
    chk("t2_span", span, 1 + NL * WORD_CYC + RC + 1);
    chk("t2_busy_gaps", bb, 0);
    chk("t2_rd_count", rd_cnt - r0, NL);
    chk("t2_done_count", done_cnt - d0 + 1, 1);
    @(negedge clk);
    chk("t2_done_pulse", done, 1'b0);
    chk("t2_busy_drop", busy, 1'b0);
    chk("t2_words_left", expq.size(), 0);
    chk("t2_err", err, 1'b0);

    // Underrun after 3 words
    for (int i = 0; i < 3; i++) begin
      fq.push_back(DW'(24'hA50000 + i));
      expq.push_back(DW'(24'hA50000 + i));
    end
    repeat (2) @(negedge clk);
    r0 = rd_cnt; d0 = done_cnt;
    frame8(0, 0, 0, span, bb);
    start = 1'b0;
    chk("t3_span", span, 1 + 3 * WORD_CYC + 1 + RC + 1);
    chk("t3_err_set", err, 1'b1);
    chk("t3_rd_count", rd_cnt - r0, 3);
    @(negedge clk);
    chk("t3_busy_drop", busy, 1'b0);
    chk("t3_done_count", done_cnt - d0, 1);
    repeat (5) @(negedge clk);
    chk("t3_err_sticky", err, 1'b1);
    chk("t3_words_left", expq.size(), 0);

    // Ignored starts while busy, then held start restarts after DONE
    for (int i = 0; i < 2 * NL; i++) begin
      fq.push_back((i == NL + 1) ? 24'hFFFFFF : DW'(24'h123456 * (i + 1)));
      expq.push_back((i == NL + 1) ? 24'hFFFFFF : DW'(24'h123456 * (i + 1)));
    end
    repeat (2) @(negedge clk);
    r0 = rd_cnt; d0 = done_cnt;
    frame8(2000, 13000, 14000, span, bb);
    chk("t5_span", span, 1 + NL * WORD_CYC + RC + 1);
    chk("t5_busy_gaps", bb, 0);
    chk("t5_rd_count", rd_cnt - r0, NL);
    @(negedge clk);
    chk("t5_done_count", done_cnt - d0, 1);
    chk("t5_idle_busy", busy, 1'b0);
    chk("t5_idle_rd_en", rd_en, 1'b0);
    @(negedge clk);
    chk("t5_restart_rd_en", rd_en, 1'b1);
    chk("t5_restart_busy", busy, 1'b1);
    start = 1'b0;

    // Reset during bit 10 of word 2 of the restarted frame
    repeat (2142) @(negedge clk);
    chk("t4_pre_reset_dout", dout, 1'b1);
    rstn = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    chk("t4_rst_dout", dout, 1'b0);
    chk("t4_rst_busy", busy, 1'b0);
    chk("t4_rst_err", err, 1'b0);
    chk("t4_rst_rd_en", rd_en, 1'b0);
    d0 = done_cnt;
    r0 = rd_cnt;
    repeat (200) @(negedge clk);
    chk("t4_no_done", done_cnt - d0, 0);
    chk("t4_no_rd_en", rd_cnt - r0, 0);
    chk("t4_idle_dout", dout, 1'b0);
    fq.delete();
    expq.delete();
    for (int i = 0; i < NL; i++) begin
      fq.push_back(DW'(24'h800001 << i));
      expq.push_back(DW'(24'h800001 << i));
    end
    repeat (2) @(negedge clk);
    r0 = rd_cnt; d0 = done_cnt;
    frame8(0, 0, 0, span, bb);
    start = 1'b0;
    chk("t4_fresh_span", span, 1 + NL * WORD_CYC + RC + 1);
    chk("t4_fresh_rd_count", rd_cnt - r0, NL);
    @(negedge clk);
    chk("t4_fresh_done_count", done_cnt - d0, 1);
    chk("t4_fresh_words_left", expq.size(), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
